// File: rtl/iiitb_rv32i_ifu.sv
// rv32i instruction fetch unit: credit-limited word fetch into an in-order prefetch FIFO.
// Define IFU_PERF_CNT_EN to add stall/flush counters. dbg_state: 0=IDLE, 1=RUN, 2=DRAIN.
module iiitb_rv32i_ifu #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 32,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk,
  input  logic          RN,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req_valid,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  output logic          id_valid,
  output logic [31:0]   id_ir,
  output logic [31:0]   id_npc,
  input  logic          id_ready,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_flush_cnt,
`endif
  output logic [1:0]    dbg_state
);

  // Both handshakes (imem request, decode pop) transfer on a clock edge where
  // valid & ready are high; valid never depends combinationally on ready.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]   fifo_ir_q  [DEPTH];
  logic [31:0]   fifo_npc_q [DEPTH];
  logic [AW-1:0] tag_q      [DEPTH];

  logic          redir, req_fire, rsp_fire, push, pop;
  logic [AW-1:0] rsp_npc;

  always_comb begin
    redir          = redirect_valid && (state_q != ST_IDLE);
    imem_req_valid = (state_q == ST_RUN) && ((count_q + inflight_q) < CW'(DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
    rsp_fire       = imem_rsp_valid && (state_q != ST_IDLE) && (inflight_q != '0);
    rsp_npc        = tag_q[tag_rd_q] + 1'b1;
    push           = rsp_fire && (state_q == ST_RUN) && !redir;
    id_valid       = (count_q != '0);
    pop            = id_valid && id_ready && !redir;
    id_ir          = id_valid ? fifo_ir_q[rd_ptr_q]  : 32'd0;
    id_npc         = id_valid ? fifo_npc_q[rd_ptr_q] : 32'd0;
    dbg_state      = state_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    tag_wr_d   = tag_wr_q + PW'(req_fire);
    tag_rd_d   = tag_rd_q + PW'(rsp_fire);
    if (req_fire) pc_d = pc_q + 1'b1;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_DRAIN: begin
        if (rsp_fire) drop_d = drop_q - 1'b1;
        if (drop_d == '0) state_d = ST_RUN;
      end
      default: state_d = state_q;
    endcase
    // Every response still outstanding after a redirect belongs to the old path.
    if (redir) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      pc_d     = redirect_pc[AW-1:0];
      drop_d   = inflight_d;
      state_d  = (inflight_d != '0) ? ST_DRAIN : ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC[AW-1:0];
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_ir_q[wr_ptr_q]  <= imem_rsp_data;
      fifo_npc_q[wr_ptr_q] <= 32'(rsp_npc);
    end
    if (req_fire) tag_q[tag_wr_q] <= pc_q;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_ready && !id_valid && (state_q != ST_IDLE) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (redir && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
